// File: rtl/pc_file.sv
// ---------------------------------------------------------------------------
// pc_file: multi-hart program-counter file and next-PC generator for a
// barrel-threaded fetch front end. Each hart is either READY (its pc may be
// fetched) or INFLIGHT (one instruction outstanding, waiting for execute to
// resolve it). A round-robin arbiter picks one READY, enabled hart per fetch
// slot. Execute resolution loads the hart's pc with the next PC and returns
// the hart to READY. Nothing is speculative.
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   hart_en_i       [NHART]      per-hart runnable mask (gates new issue only)
//   fetch_ready_i                fetch accepts an address this cycle
//   fetch_valid_o                some hart is READY and enabled
//   fetch_hart_o    [HART_W]     selected hart
//   fetch_pc_o      [XLEN]       pc of the selected hart
//   ex_valid_i                   execute resolves one instruction
//   ex_hart_i       [HART_W]     hart of the resolving instruction
//   ex_pc_i         [XLEN]       pc of the resolving instruction
//   ex_compressed_i              resolving instruction is 16-bit
//   s_jump_i, s_jalr_i, s_branch_i, s_branch_zero_i, s_exception_i, alu_z_i
//                                decode/ALU controls
//   imm_i, alu_o_i, csr_pc_i [XLEN] branch offset, jump target, trap target
//   branch_take_o                conditional branch is taken
//   misaligned_o                 jump/taken-branch target is misaligned
// ---------------------------------------------------------------------------
module pc_file #(
    parameter int              XLEN         = 32,
    parameter int              NHART        = 4,
    parameter logic [XLEN-1:0] RESET        = '0,
    parameter logic [XLEN-1:0] RESET_STRIDE = '0,
    parameter bit              C_EXT        = 1'b0,
    localparam int             HART_W       = $clog2(NHART)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NHART-1:0]  hart_en_i,
    input  logic              fetch_ready_i,
    output logic              fetch_valid_o,
    output logic [HART_W-1:0] fetch_hart_o,
    output logic [XLEN-1:0]   fetch_pc_o,
    input  logic              ex_valid_i,
    input  logic [HART_W-1:0] ex_hart_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic              ex_compressed_i,
    input  logic              s_jump_i,
    input  logic              s_jalr_i,
    input  logic              s_branch_i,
    input  logic              s_branch_zero_i,
    input  logic              s_exception_i,
    input  logic              alu_z_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   alu_o_i,
    input  logic [XLEN-1:0]   csr_pc_i,
    output logic              branch_take_o,
    output logic              misaligned_o
);

    // Per-hart state: 1 = INFLIGHT, 0 = READY.
    logic [NHART-1:0]            inflight_q, inflight_d;
    logic [NHART-1:0][XLEN-1:0]  pc_q, pc_d;
    logic [HART_W-1:0]           last_q, last_d;

    logic [NHART-1:0]  elig;
    logic              sel_vld;
    logic [HART_W-1:0] sel;
    logic              issue, resolve;
    logic [XLEN-1:0]   jump_tgt, br_tgt, chk_tgt, seq_pc, npc;
    logic              tgt_used, tgt_bad;

    assign elig    = hart_en_i & ~inflight_q;
    assign issue   = sel_vld && fetch_ready_i;
    // Responses for READY harts (e.g. stale ones across a reset) are dropped.
    assign resolve = ex_valid_i && inflight_q[ex_hart_i];

    // Round-robin: first eligible hart starting just after the last issued.
    always_comb begin
        logic [HART_W-1:0] idx;
        sel_vld = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int i = 1; i <= NHART; i++) begin
            idx = last_q + HART_W'(i);
            if (!sel_vld && elig[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    // Next-PC datapath.
    assign branch_take_o = s_branch_i && (s_branch_zero_i ~^ alu_z_i);
    assign jump_tgt      = s_jalr_i ? {alu_o_i[XLEN-1:1], 1'b0} : alu_o_i;
    assign br_tgt        = ex_pc_i + imm_i;
    assign seq_pc        = ex_pc_i + (ex_compressed_i ? XLEN'(2) : XLEN'(4));
    assign chk_tgt       = s_jump_i ? jump_tgt : br_tgt;
    // An exception already redirects to csr_pc, so the jump/branch target is
    // never taken and must not raise a second (misalignment) trap.
    assign tgt_used      = !s_exception_i && (s_jump_i || branch_take_o);
    assign tgt_bad       = C_EXT ? chk_tgt[0] : (chk_tgt[1] | chk_tgt[0]);

    always_comb begin
        if (s_exception_i)           npc = csr_pc_i;
        else if (tgt_used && tgt_bad) npc = csr_pc_i;
        else if (s_jump_i)           npc = jump_tgt;
        else if (branch_take_o)      npc = br_tgt;
        else                         npc = seq_pc;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
            last_q     <= HART_W'(NHART - 1);
            for (int h = 0; h < NHART; h++)
                pc_q[h] <= RESET + XLEN'(h) * RESET_STRIDE;
        end else begin
            inflight_q <= inflight_d;
            last_q     <= last_d;
            pc_q       <= pc_d;
        end
    end

    // Next-state logic. An issuing hart is READY and a resolving hart is
    // INFLIGHT, so the two updates never target the same hart.
    always_comb begin
        inflight_d = inflight_q;
        pc_d       = pc_q;
        last_d     = last_q;
        if (issue) begin
            inflight_d[sel] = 1'b1;
            last_d          = sel;
        end
        if (resolve) begin
            inflight_d[ex_hart_i] = 1'b0;
            pc_d[ex_hart_i]       = npc;
        end
    end

    // Outputs.
    always_comb begin
        fetch_valid_o = sel_vld;
        fetch_hart_o  = sel;
        fetch_pc_o    = pc_q[sel];
        misaligned_o  = resolve && tgt_used && tgt_bad;
    end

endmodule

// File: tb/tb_pc_file.sv
module tb_pc_file;
    localparam int XLEN = 32;
    localparam int NH   = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NH-1:0]   hart_en;
    logic            fetch_ready;
    logic            ex_valid, ex_compressed;
    logic [1:0]      ex_hart;
    logic [XLEN-1:0] ex_pc, imm, alu_o, csr_pc;
    logic            s_jump, s_jalr, s_branch, s_branch_zero, s_exception, alu_z;

    logic            fv0, fv1, bt0, bt1, mis0, mis1;
    logic [1:0]      fh0, fh1;
    logic [XLEN-1:0] fp0, fp1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pc_file #(.XLEN(XLEN), .NHART(NH), .RESET(32'h100), .RESET_STRIDE(32'h1000), .C_EXT(1'b0)) dut0 (
        .clock(clock), .reset(reset), .hart_en_i(hart_en), .fetch_ready_i(fetch_ready),
        .fetch_valid_o(fv0), .fetch_hart_o(fh0), .fetch_pc_o(fp0),
        .ex_valid_i(ex_valid), .ex_hart_i(ex_hart), .ex_pc_i(ex_pc), .ex_compressed_i(ex_compressed),
        .s_jump_i(s_jump), .s_jalr_i(s_jalr), .s_branch_i(s_branch), .s_branch_zero_i(s_branch_zero),
        .s_exception_i(s_exception), .alu_z_i(alu_z), .imm_i(imm), .alu_o_i(alu_o), .csr_pc_i(csr_pc),
        .branch_take_o(bt0), .misaligned_o(mis0));

    pc_file #(.XLEN(XLEN), .NHART(NH), .RESET(32'h100), .RESET_STRIDE(32'h1000), .C_EXT(1'b1)) dut1 (
        .clock(clock), .reset(reset), .hart_en_i(hart_en), .fetch_ready_i(fetch_ready),
        .fetch_valid_o(fv1), .fetch_hart_o(fh1), .fetch_pc_o(fp1),
        .ex_valid_i(ex_valid), .ex_hart_i(ex_hart), .ex_pc_i(ex_pc), .ex_compressed_i(ex_compressed),
        .s_jump_i(s_jump), .s_jalr_i(s_jalr), .s_branch_i(s_branch), .s_branch_zero_i(s_branch_zero),
        .s_exception_i(s_exception), .alu_z_i(alu_z), .imm_i(imm), .alu_o_i(alu_o), .csr_pc_i(csr_pc),
        .branch_take_o(bt1), .misaligned_o(mis1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clr_ex();
        ex_valid = 0; ex_hart = 0; ex_pc = 0; ex_compressed = 0;
        s_jump = 0; s_jalr = 0; s_branch = 0; s_branch_zero = 0; s_exception = 0; alu_z = 0;
        imm = 0; alu_o = 0; csr_pc = 0;
    endtask

    // Plain fall-through resolve of hart h at pc p.
    task automatic ex_seq(input logic [1:0] h, input logic [31:0] p);
        clr_ex();
        ex_valid = 1; ex_hart = h; ex_pc = p;
    endtask

    task automatic exp_fetch(input string tag, input logic [1:0] h, input logic [31:0] p);
        #1;
        chk({tag, ".valid"}, 32'(fv0), 32'd1);
        chk({tag, ".hart"},  32'(fh0), 32'(h));
        chk({tag, ".pc"},    fp0, p);
    endtask

    initial begin
        clr_ex();
        reset = 1; hart_en = 4'hF; fetch_ready = 0;
        tick(); tick();
        reset = 0;

        // Reset state: hart 0 selected first (last = 3).
        exp_fetch("rst", 2'd0, 32'h100);

        // Back-to-back issue of all four harts.
        fetch_ready = 1;
        for (int k = 0; k < NH; k++) begin
            exp_fetch($sformatf("iss%0d", k), 2'(k), 32'h100 + 32'(k) * 32'h1000);
            tick();
        end
        #1 chk("all_inflight.valid", 32'(fv0), 32'd0);

        // Taken branch on hart 2.
        ex_valid = 1; ex_hart = 2; ex_pc = 32'h2100;
        s_branch = 1; s_branch_zero = 1; alu_z = 1; imm = 32'h40;
        #1 chk("br.take", 32'(bt0), 32'd1);
        chk("br.mis", 32'(mis0), 32'd0);
        tick(); clr_ex();
        exp_fetch("br", 2'd2, 32'h2140);
        tick();

        // jalr to 0x3103 on hart 3: bit0 cleared, then bit1 still bad w/o C.
        ex_valid = 1; ex_hart = 3; ex_pc = 32'h3100;
        s_jump = 1; s_jalr = 1; alu_o = 32'h3103; csr_pc = 32'h80;
        #1 chk("jalr.mis_c0", 32'(mis0), 32'd1);
        chk("jalr.mis_c1", 32'(mis1), 32'd0);
        tick(); clr_ex();
        exp_fetch("jalr_c0", 2'd3, 32'h80);
        chk("jalr_c1.hart", 32'(fh1), 32'd3);
        chk("jalr_c1.pc", fp1, 32'h3102);
        tick();

        // Compressed fall-through wraps to 0.
        ex_seq(2'd0, 32'hFFFF_FFFE); ex_compressed = 1;
        #1 chk("wrap.mis", 32'(mis0), 32'd0);
        tick(); clr_ex();
        exp_fetch("wrap", 2'd0, 32'h0);
        tick();

        // Exception beats jump.
        ex_seq(2'd1, 32'hFFFF_FFFE); ex_compressed = 1;
        s_exception = 1; s_jump = 1; alu_o = 32'h3104; csr_pc = 32'h200;
        tick(); clr_ex();
        exp_fetch("exc", 2'd1, 32'h200);
        tick();
        #1 chk("exc.all_inflight", 32'(fv0), 32'd0);

        // Only harts 1 and 3 enabled. Resolving 0 and 2 yields nothing to fetch.
        hart_en = 4'b1010;
        ex_seq(2'd0, 32'h0);
        tick(); clr_ex();
        #1 chk("en.h0_blocked", 32'(fv0), 32'd0);
        ex_seq(2'd2, 32'h2140);
        tick(); clr_ex();
        #1 chk("en.h2_blocked", 32'(fv0), 32'd0);
        // ex_valid for READY hart 0: ignored, no misaligned.
        clr_ex(); ex_valid = 1; ex_hart = 0; s_jump = 1; alu_o = 32'h3; csr_pc = 32'hDEAD0;
        #1 chk("stale.mis", 32'(mis0), 32'd0);
        tick(); clr_ex();
        #1 chk("stale.valid", 32'(fv0), 32'd0);
        ex_seq(2'd3, 32'h80);
        tick(); clr_ex();
        exp_fetch("rr3a", 2'd3, 32'h84);
        tick();
        ex_seq(2'd1, 32'h200);
        tick(); clr_ex();
        exp_fetch("rr1a", 2'd1, 32'h204);
        tick();
        ex_seq(2'd3, 32'h84);
        tick(); clr_ex();
        exp_fetch("rr3b", 2'd3, 32'h88);
        // Hart 3 issues while hart 1 resolves in the same cycle.
        ex_seq(2'd1, 32'h204);
        tick(); clr_ex();
        exp_fetch("rr1b", 2'd1, 32'h208);
        tick();
        #1 chk("rr.none", 32'(fv0), 32'd0);

        // Hart 0 kept pc 4 despite the ignored ex_valid.
        fetch_ready = 0; hart_en = 4'b0001;
        exp_fetch("h0_kept", 2'd0, 32'h4);
        hart_en = 4'hF;

        // Reset with harts 1 and 3 in flight, then stale responses.
        reset = 1;
        tick();
        reset = 0;
        ex_seq(2'd1, 32'h204); s_exception = 1; csr_pc = 32'h999;
        tick();
        ex_seq(2'd3, 32'h88); s_jump = 1; alu_o = 32'h3;
        #1 chk("rst_stale.mis", 32'(mis0), 32'd0);
        tick(); clr_ex();
        fetch_ready = 1;
        for (int k = 0; k < NH; k++) begin
            exp_fetch($sformatf("rst_iss%0d", k), 2'(k), 32'h100 + 32'(k) * 32'h1000);
            tick();
        end
        #1 chk("rst.all_inflight", 32'(fv0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
